conv_window_streamer: RTL and testbench

Upstream feeder for the 3x3 convolution stage. Accepts a 7x7 frame of 8-bit pixels serially in raster order over a valid/ready handshake and buffers it. It then emits every stride-2 3x3 window of that frame, one per handshake, as a flattened bus. The convolution stage consumes each window and multiplies it against its flipped kernel.

---
 rtl/conv_window_streamer.sv | 209 ++++++++++++++++++++
 tb/tb_conv_window_streamer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_streamer.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_streamer
// Function : Buffers an MxM pixel frame (raster order, valid/ready) and streams
//            every stride-STRIDE KSIZExKSIZE window as a registered flat bus.
//            Optional: define CONV_WIN_PINGPONG_EN for two banks (load while emit).
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_streamer #(
    parameter  int M      = 7,
    parameter  int KSIZE  = 3,
    parameter  int STRIDE = 2,
    parameter  int DW     = 8,
    localparam int OUT_N  = (M - KSIZE) / STRIDE + 1,
    localparam int CW     = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DW-1:0]             pix_data,
    input  logic                      pix_valid,
    input  logic                      pix_first,
    output logic                      pix_ready,
    output logic [DW*KSIZE*KSIZE-1:0] win_data,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [CW-1:0]             win_row,
    output logic [CW-1:0]             win_col,
    output logic                      win_last,
    output logic                      sync_err,
    output logic [7:0]                frames_done
);

`ifdef CONV_WIN_PINGPONG_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam int NPIX  = M * M;
    localparam int DEPTH = NBANK * NPIX;
    localparam int IW    = $clog2(NPIX);
    localparam int AW    = $clog2(DEPTH);
    localparam int WW    = DW * KSIZE * KSIZE;
    localparam logic [CW-1:0] LAST_RC = CW'(OUT_N - 1);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] fbuf [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [1:0]    full;
    logic [1:0]    full_next;
    logic          load_bank;
    logic          load_bank_next;
    logic          emit_bank;
    logic          other_bank;
    logic          pix_accept;
    logic          resync;
    logic          load_done;
    logic          win_hs;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] row_next;
    logic [CW-1:0] col_next;
    logic          last_next;
    logic          sel_bank;
    logic [CW-1:0] sel_row;
    logic [CW-1:0] sel_col;
    logic [WW-1:0] gather;

    // In the single-bank build both bank pointers stay at 0.
    function automatic logic flip(input logic b);
        return b ^ (NBANK == 2);
    endfunction

    function automatic logic [AW-1:0] bank_base(input logic b);
        return b ? AW'(NPIX) : '0;
    endfunction

    always_comb begin
        pix_accept = pix_valid && pix_ready;
        win_hs     = win_valid && win_ready;
        resync     = pix_accept && pix_first && (wr_idx != '0);
        load_done  = pix_accept && !resync && (wr_idx == IW'(NPIX - 1));
        wr_addr    = bank_base(load_bank) + (resync ? '0 : AW'(wr_idx));

        full_next = full;
        if (load_done) begin
            full_next[load_bank] = 1'b1;
        end
        if (win_hs && win_last) begin
            full_next[emit_bank] = 1'b0;
        end
        load_bank_next = load_done ? flip(load_bank) : load_bank;
        other_bank     = flip(emit_bank);

        if (win_col == LAST_RC) begin
            col_next = '0;
            row_next = win_row + CW'(1);
        end else begin
            col_next = win_col + CW'(1);
            row_next = win_row;
        end
        last_next = (row_next == LAST_RC) && (col_next == LAST_RC);

        // Window to load on the next update: the following window of the
        // current frame, or (0,0) of whichever bank starts emitting.
        if (state == ST_EMIT && !win_last) begin
            sel_bank = emit_bank;
            sel_row  = row_next;
            sel_col  = col_next;
        end else begin
            sel_bank = (state == ST_EMIT) ? other_bank : emit_bank;
            sel_row  = '0;
            sel_col  = '0;
        end
    end

    // Window (0,0) never touches the final raster pixel, so it can be
    // gathered on the same edge that writes that pixel.
    always_comb begin
        gather = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                gather[DW*(r*KSIZE+c) +: DW] = fbuf[bank_base(sel_bank)
                    + AW'((STRIDE * int'(sel_row) + r) * M
                          + STRIDE * int'(sel_col) + c)];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (pix_accept) begin
            fbuf[wr_addr] <= pix_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_LOAD;
            wr_idx      <= '0;
            full        <= '0;
            load_bank   <= 1'b0;
            emit_bank   <= 1'b0;
            pix_ready   <= 1'b1;
            win_valid   <= 1'b0;
            win_data    <= '0;
            win_row     <= '0;
            win_col     <= '0;
            win_last    <= 1'b0;
            sync_err    <= 1'b0;
            frames_done <= '0;
        end else begin
            sync_err  <= resync;
            full      <= full_next;
            load_bank <= load_bank_next;
            pix_ready <= !full_next[load_bank_next];

            if (pix_accept) begin
                if (resync) begin
                    wr_idx <= IW'(1);
                end else if (load_done) begin
                    wr_idx <= '0;
                end else begin
                    wr_idx <= wr_idx + IW'(1);
                end
            end

            case (state)
                ST_LOAD: begin
                    if (full_next[emit_bank]) begin
                        state     <= ST_EMIT;
                        win_valid <= 1'b1;
                        win_row   <= '0;
                        win_col   <= '0;
                        win_last  <= (OUT_N == 1);
                        win_data  <= gather;
                    end
                end
                ST_EMIT: begin
                    if (win_hs) begin
                        if (win_last) begin
                            frames_done <= frames_done + 8'd1;
                            emit_bank   <= other_bank;
                            if (full_next[other_bank]) begin
                                win_row  <= '0;
                                win_col  <= '0;
                                win_last <= (OUT_N == 1);
                                win_data <= gather;
                            end else begin
                                state     <= ST_LOAD;
                                win_valid <= 1'b0;
                            end
                        end else begin
                            win_row  <= row_next;
                            win_col  <= col_next;
                            win_last <= last_next;
                            win_data <= gather;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_streamer
// Function : Directed self-checking bench for conv_window_streamer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_streamer;

    localparam int DW = 8;
    localparam int WW = 72;

    localparam logic [WW-1:0] W00 = {8'd16, 8'd15, 8'd14, 8'd9,  8'd8,  8'd7,  8'd2,  8'd1,  8'd0};
    localparam logic [WW-1:0] W12 = {8'd34, 8'd33, 8'd32, 8'd27, 8'd26, 8'd25, 8'd20, 8'd19, 8'd18};
    localparam logic [WW-1:0] W22 = {8'd48, 8'd47, 8'd46, 8'd41, 8'd40, 8'd39, 8'd34, 8'd33, 8'd32};

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_first = 1'b0;
    logic          pix_ready;
    logic [WW-1:0] win_data;
    logic          win_valid;
    logic          win_ready = 1'b0;
    logic [1:0]    win_row;
    logic [1:0]    win_col;
    logic          win_last;
    logic          sync_err;
    logic [7:0]    frames_done;

    int checks   = 0;
    int failures = 0;

    conv_window_streamer dut (
        .clock       (clock),
        .reset       (reset),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_first   (pix_first),
        .pix_ready   (pix_ready),
        .win_data    (win_data),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_row     (win_row),
        .win_col     (win_col),
        .win_last    (win_last),
        .sync_err    (sync_err),
        .frames_done (frames_done)
    );

    always #5 clock = ~clock;

    // Frame pixel (r,c) carries base + r*7 + c.
    function automatic logic [WW-1:0] exp_win(input int base, input int wr, input int wc);
        logic [WW-1:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v[DW*(i*3+j) +: DW] = 8'(base + (2*wr + i)*7 + 2*wc + j);
            end
        end
        return v;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send_pix(input logic [7:0] v, input logic first);
        int n;
        n = 0;
        pix_data  = v;
        pix_first = first;
        pix_valid = 1'b1;
        while (!pix_ready && n < 200) begin
            tick();
            n++;
        end
        if (!pix_ready) begin
            failures++;
            $display("FAIL pix_ready_timeout got=%0b exp=1", pix_ready);
        end
        tick();
        pix_valid = 1'b0;
        pix_first = 1'b0;
    endtask

    task automatic send_frame(input int base, input logic first);
        for (int i = 0; i < 49; i++) begin
            send_pix(8'(base + i), first && (i == 0));
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if (pix_ready !== 1'b1 || win_valid !== 1'b0 || win_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got ready=%b valid=%b last=%b exp 1 0 0", pix_ready, win_valid, win_last);
        end
        checks++;
        if (win_data !== '0 || win_row !== 2'd0 || win_col !== 2'd0) begin
            failures++;
            $display("FAIL reset_window got data=%h row=%0d col=%0d exp 0", win_data, win_row, win_col);
        end
        checks++;
        if (sync_err !== 1'b0 || frames_done !== 8'd0) begin
            failures++;
            $display("FAIL reset_status got sync_err=%b frames=%0d exp 0 0", sync_err, frames_done);
        end
    endtask

    task automatic test_basic;
        win_ready = 1'b1;
        send_frame(0, 1'b1);
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (win_valid !== 1'b1 || win_row !== 2'(n/3) || win_col !== 2'(n%3) || win_last !== (n == 8)) begin
                failures++;
                $display("FAIL basic_ctrl n=%0d got v=%b r=%0d c=%0d l=%b exp 1 %0d %0d %b",
                         n, win_valid, win_row, win_col, win_last, n/3, n%3, n == 8);
            end
            checks++;
            if (win_data !== exp_win(0, n/3, n%3)) begin
                failures++;
                $display("FAIL basic_data n=%0d got=%h exp=%h", n, win_data, exp_win(0, n/3, n%3));
            end
            if (n == 0 || n == 5 || n == 8) begin
                checks++;
                if (win_data !== ((n == 0) ? W00 : (n == 5) ? W12 : W22)) begin
                    failures++;
                    $display("FAIL basic_hand n=%0d got=%h", n, win_data);
                end
            end
`ifndef CONV_WIN_PINGPONG_EN
            checks++;
            if (pix_ready !== 1'b0) begin
                failures++;
                $display("FAIL basic_ready_emit n=%0d got=%b exp=0", n, pix_ready);
            end
`endif
            tick();
        end
        checks++;
        if (win_valid !== 1'b0 || frames_done !== 8'd1 || pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_end got v=%b frames=%0d ready=%b exp 0 1 1", win_valid, frames_done, pix_ready);
        end
    endtask

    task automatic test_backpressure;
        win_ready = 1'b0;
        send_frame(0, 1'b1);
        checks++;
        if (win_valid !== 1'b1 || win_data !== W00) begin
            failures++;
            $display("FAIL bp_first got v=%b data=%h exp=%h", win_valid, win_data, W00);
        end
        win_ready = 1'b1;
        tick();
        win_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (win_valid !== 1'b1 || win_row !== 2'd0 || win_col !== 2'd1 || win_data !== exp_win(0, 0, 1)) begin
                failures++;
                $display("FAIL bp_hold k=%0d got v=%b r=%0d c=%0d data=%h exp=%h",
                         k, win_valid, win_row, win_col, win_data, exp_win(0, 0, 1));
            end
            tick();
        end
        win_ready = 1'b1;
        for (int n = 1; n < 9; n++) begin
            checks++;
            if (win_row !== 2'(n/3) || win_col !== 2'(n%3) || win_data !== exp_win(0, n/3, n%3)) begin
                failures++;
                $display("FAIL bp_seq n=%0d got r=%0d c=%0d data=%h exp=%h",
                         n, win_row, win_col, win_data, exp_win(0, n/3, n%3));
            end
            tick();
        end
        checks++;
        if (win_valid !== 1'b0 || frames_done !== 8'd2) begin
            failures++;
            $display("FAIL bp_end got v=%b frames=%0d exp 0 2", win_valid, frames_done);
        end
    endtask

    task automatic test_resync;
        int pulses;
        pulses = 0;
        win_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_pix(8'(i), i == 0);
        end
        checks++;
        if (sync_err !== 1'b0) begin
            failures++;
            $display("FAIL resync_quiet got=%b exp=0", sync_err);
        end
        send_pix(8'd100, 1'b1);
        checks++;
        if (sync_err !== 1'b1) begin
            failures++;
            $display("FAIL resync_pulse got=%b exp=1", sync_err);
        end
        for (int i = 1; i < 49; i++) begin
            send_pix(8'(100 + i), 1'b0);
            if (sync_err === 1'b1) pulses++;
            if (i == 47) begin
                checks++;
                if (win_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL resync_early_window got=%b exp=0", win_valid);
                end
            end
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL resync_extra_pulses got=%0d exp=0", pulses);
        end
        checks++;
        if (win_valid !== 1'b1 || win_data[7:0] !== 8'd100) begin
            failures++;
            $display("FAIL resync_first_pix got v=%b pix=%0d exp 1 100", win_valid, win_data[7:0]);
        end
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (win_row !== 2'(n/3) || win_col !== 2'(n%3) || win_data !== exp_win(100, n/3, n%3)) begin
                failures++;
                $display("FAIL resync_win n=%0d got r=%0d c=%0d data=%h exp=%h",
                         n, win_row, win_col, win_data, exp_win(100, n/3, n%3));
            end
            tick();
        end
        checks++;
        if (frames_done !== 8'd3) begin
            failures++;
            $display("FAIL resync_frames got=%0d exp=3", frames_done);
        end
    endtask

    task automatic test_reset_mid_emit;
        win_ready = 1'b1;
        send_frame(50, 1'b1);
        repeat (4) tick();
        checks++;
        if (win_valid !== 1'b1 || win_row !== 2'd1 || win_col !== 2'd1) begin
            failures++;
            $display("FAIL mid_pre got v=%b r=%0d c=%0d exp 1 1 1", win_valid, win_row, win_col);
        end
        reset = 1'b1;
        #2;
        checks++;
        if (win_valid !== 1'b0 || pix_ready !== 1'b1 || frames_done !== 8'd0 || win_data !== '0) begin
            failures++;
            $display("FAIL mid_reset got v=%b ready=%b frames=%0d data=%h exp 0 1 0 0",
                     win_valid, pix_ready, frames_done, win_data);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        send_frame(0, 1'b0);
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (win_valid !== 1'b1 || win_row !== 2'(n/3) || win_col !== 2'(n%3) ||
                win_data !== exp_win(0, n/3, n%3) || sync_err !== 1'b0) begin
                failures++;
                $display("FAIL mid_after n=%0d got v=%b r=%0d c=%0d se=%b data=%h exp=%h",
                         n, win_valid, win_row, win_col, sync_err, win_data, exp_win(0, n/3, n%3));
            end
            tick();
        end
        checks++;
        if (frames_done !== 8'd1) begin
            failures++;
            $display("FAIL mid_frames got=%0d exp=1", frames_done);
        end
    endtask

`ifdef CONV_WIN_PINGPONG_EN
    task automatic test_pingpong;
        int base;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        win_ready = 1'b0;
        send_frame(0, 1'b1);
        checks++;
        if (win_valid !== 1'b1 || pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL pp_load_during_emit got v=%b ready=%b exp 1 1", win_valid, pix_ready);
        end
        send_frame(60, 1'b1);
        checks++;
        if (pix_ready !== 1'b0 || win_data !== W00) begin
            failures++;
            $display("FAIL pp_both_full got ready=%b data=%h exp 0 %h", pix_ready, win_data, W00);
        end
        for (int f = 0; f < 2; f++) begin
            base = (f == 0) ? 0 : 60;
            for (int n = 0; n < 9; n++) begin
                checks++;
                if (win_valid !== 1'b1 || win_row !== 2'(n/3) || win_col !== 2'(n%3) ||
                    win_data !== exp_win(base, n/3, n%3)) begin
                    failures++;
                    $display("FAIL pp_win f=%0d n=%0d got v=%b r=%0d c=%0d data=%h exp=%h",
                             f, n, win_valid, win_row, win_col, win_data, exp_win(base, n/3, n%3));
                end
                win_ready = 1'b0;
                tick();
                win_ready = 1'b1;
                tick();
            end
        end
        win_ready = 1'b0;
        checks++;
        if (frames_done !== 8'd2 || win_valid !== 1'b0) begin
            failures++;
            $display("FAIL pp_end got frames=%0d v=%b exp 2 0", frames_done, win_valid);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_resync();
        test_reset_mid_emit();
`ifdef CONV_WIN_PINGPONG_EN
        test_pingpong();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
